apb_master_bridge: RTL and testbench
====================================

// Module: apb_master_bridge
// PURPOSE
//   Parametrised APB4 master: turns a single-outstanding valid/ready command port into APB
//   SETUP/ACCESS transfers to NUM_SLV slaves. Supports PREADY wait states, PSTRB byte strobes,
//   per-slave PSLVERR, address-decode errors and an optional PREADY timeout.
//   Sits between the stimulus/CPU side and the APB slave fabric; successor to the fixed 8-bit/9-bit transfer wrapper.
// PARAMETERS
//   ADDR_W      12  address width; slave index = PADDR[ADDR_W-1 -: SEL_W], SEL_W=$clog2(NUM_SLV) (min 1)
//   DATA_W      32  data width, multiple of 8; STRB_W = DATA_W/8
//   NUM_SLV     3   number of APB slaves (PSEL bits); index >= NUM_SLV is a decode error
//   TIMEOUT_CYC 16  max ACCESS cycles with PREADY low (used only with APB_TIMEOUT_EN)
// PORTS
//   PCLK       in   1              clock, all logic on rising edge
//   PRESET     in   1              synchronous, active-high reset
//   cmd_valid  in   1              command request
//   cmd_ready  out  1              command accepted when cmd_valid && cmd_ready
//   cmd_write  in   1              1 = write, 0 = read
//   cmd_addr   in   ADDR_W         transfer address
//   cmd_wdata  in   DATA_W         write data
//   cmd_strb   in   STRB_W         write byte strobes
//   rsp_valid  out  1              one-cycle completion pulse, no backpressure
//   rsp_rdata  out  DATA_W         read data (0 for writes and errors)
//   rsp_err    out  1              PSLVERR, decode error or timeout
//   PSEL       out  NUM_SLV        one-hot slave select
//   PENABLE    out  1              ACCESS phase
//   PWRITE     out  1              APB direction
//   PADDR      out  ADDR_W         APB address
//   PWDATA     out  DATA_W         APB write data
//   PSTRB      out  STRB_W         APB strobes (0 on reads)
//   PRDATA     in   NUM_SLV*DATA_W slave s read data at [s*DATA_W +: DATA_W]
//   PREADY     in   NUM_SLV        per-slave ready
//   PSLVERR    in   NUM_SLV        per-slave error, sampled only with PREADY
// BEHAVIOUR
//   - Reset (PRESET high at edge): every output 0, incl. cmd_ready; FSM -> IDLE; in-flight transfer dropped, no rsp.
//   - FSM IDLE/SETUP/ACCESS. cmd_ready = (state==IDLE) && !PRESET. Command registered on acceptance.
//   - IDLE: accept valid index -> SETUP; accept invalid index -> stay IDLE, rsp_valid=1 rsp_err=1 next cycle, no PSEL.
//   - SETUP: PSEL[idx]=1, PENABLE=0, PADDR/PWRITE/PWDATA/PSTRB from latched cmd -> ACCESS unconditionally.
//   - ACCESS: PENABLE=1; stay while PREADY[idx]==0; on PREADY[idx]==1 -> IDLE, capture PRDATA slice (reads)
//     and PSLVERR[idx] into rsp_rdata/rsp_err, rsp_valid=1 the following cycle.
//   - Zero-wait latency: accept at t, SETUP t+1, ACCESS t+2, rsp_valid + cmd_ready at t+3; back-to-back every 3 cycles.
//   - PADDR/PWRITE/PWDATA/PSTRB stable from SETUP to end of ACCESS; hold last values in IDLE.
//   - PREADY/PSLVERR/PRDATA of non-selected slaves ignored; rsp_rdata/rsp_err held 0 except in rsp_valid cycle.
// CONFIGURATION
//   APB_TIMEOUT_EN defined: counter clears on SETUP, increments per ACCESS cycle with PREADY low; on
//     reaching TIMEOUT_CYC -> PSEL/PENABLE drop next cycle, FSM IDLE, rsp_valid=1 rsp_err=1 rsp_rdata=0.
//   Undefined: no counter, ACCESS waits indefinitely; TIMEOUT_CYC unused.
// STRUCTURE
//   apb_bridge_pkg: state enum typedef (IDLE/SETUP/ACCESS), default width localparams.
//   Sub-module apb_slave_decode: cmd_addr -> slave index, one-hot select, index_valid (combinational).
// TESTING
//   1 write 0x504 data 0xDEADBEEF strb 0xF, slave1 PREADY=1 -> PSEL=3'b010 t+1 PENABLE=0, t+2 PENABLE=1, rsp t+3 err=0.
//   2 read 0x808, slave2 PREADY low 3 cycles, PRDATA=0x12345678 -> 4 ACCESS cycles, PSTRB=0, rsp_rdata=0x12345678.
//   3 read 0x010, slave0 PSLVERR=1 with PREADY -> rsp_err=1, rsp_rdata=0; PSLVERR without PREADY ignored.
//   4 cmd_addr 0xC00 (index 3) -> PSEL stays 0, rsp_valid t+1 with rsp_err=1, cmd_ready high again t+1.
//   5 PRESET pulsed during ACCESS -> PSEL=0, PENABLE=0 next cycle, no rsp_valid, cmd_ready=1 after release.
//   6 PREADY held 0: APB_TIMEOUT_EN -> abort after 16 ACCESS cycles, rsp_err=1; no macro -> still ACCESS at 100 cycles.

Source files
------------

// File: rtl/apb_bridge_pkg.sv
// Shared types and default sizes for the APB4 master bridge.
package apb_bridge_pkg;

  localparam int DEF_ADDR_W      = 12;
  localparam int DEF_DATA_W      = 32;
  localparam int DEF_NUM_SLV     = 3;
  localparam int DEF_TIMEOUT_CYC = 16;

  // Transfer phases; the encoding is visible on the bridge debug port.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

  // Width of the slave index field at the top of the address (at least 1 bit).
  function automatic int sel_width(input int num_slv);
    return (num_slv > 1) ? $clog2(num_slv) : 1;
  endfunction

endpackage

// File: rtl/apb_slave_decode.sv
// Address decoder: top SEL_W address bits pick the slave; indices at or
// beyond NUM_SLV are flagged invalid and select nobody.
module apb_slave_decode
  import apb_bridge_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int NUM_SLV = DEF_NUM_SLV,
  parameter int SEL_W   = sel_width(NUM_SLV)
) (
  input  logic [ADDR_W-1:0]  cmd_addr,
  output logic [SEL_W-1:0]   slv_idx,
  output logic [NUM_SLV-1:0] slv_onehot,
  output logic               index_valid
);

  // Offset bits inside a slave window play no part in decoding.
  logic unused_low_addr;
  assign unused_low_addr = ^cmd_addr[ADDR_W-SEL_W-1:0];

  assign slv_idx     = cmd_addr[ADDR_W-1 -: SEL_W];
  assign index_valid = (int'(slv_idx) < NUM_SLV);

  // One-hot slave select, empty for an out-of-range index.
  always_comb begin
    slv_onehot = '0;
    for (int s = 0; s < NUM_SLV; s++) begin
      if (index_valid && (slv_idx == SEL_W'(s))) slv_onehot[s] = 1'b1;
    end
  end

endmodule

// File: rtl/apb_master_bridge.sv
// APB4 master bridge: one outstanding command turned into SETUP/ACCESS
// transfers on NUM_SLV slaves.
// Optional feature: define APB_TIMEOUT_EN to abort an ACCESS phase after
// TIMEOUT_CYC cycles with PREADY low (reported as rsp_err).
// Handshake: a command transfers on a rising PCLK edge where cmd_valid &&
// cmd_ready; rsp_valid is a single-cycle pulse with no backpressure, and
// rsp_err/rsp_rdata are zero outside that pulse.
module apb_master_bridge
  import apb_bridge_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int NUM_SLV     = DEF_NUM_SLV,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic                      PCLK,
  input  logic                      PRESET,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic                      cmd_write,
  input  logic [ADDR_W-1:0]         cmd_addr,
  input  logic [DATA_W-1:0]         cmd_wdata,
  input  logic [DATA_W/8-1:0]       cmd_strb,
  output logic                      rsp_valid,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic                      rsp_err,
  output logic [NUM_SLV-1:0]        PSEL,
  output logic                      PENABLE,
  output logic                      PWRITE,
  output logic [ADDR_W-1:0]         PADDR,
  output logic [DATA_W-1:0]         PWDATA,
  output logic [DATA_W/8-1:0]       PSTRB,
  input  logic [NUM_SLV*DATA_W-1:0] PRDATA,
  input  logic [NUM_SLV-1:0]        PREADY,
  input  logic [NUM_SLV-1:0]        PSLVERR,
  output apb_state_e                dbg_state
);

  localparam int STRB_W = DATA_W / 8;
  localparam int SEL_W  = sel_width(NUM_SLV);

  if (((DATA_W % 8) != 0) || (TIMEOUT_CYC < 1)) begin : g_param_check
    $error("apb_master_bridge: DATA_W must be a multiple of 8 and TIMEOUT_CYC at least 1");
  end

  apb_state_e         state_q, state_d;
  logic [SEL_W-1:0]   dec_idx, idx_q;
  logic [NUM_SLV-1:0] dec_onehot, psel_q;
  logic               dec_valid, accept;
  logic               sel_ready, sel_err, tmo_hit;
  logic [DATA_W-1:0]  sel_rdata;
  logic               rsp_valid_d, rsp_err_d;
  logic [DATA_W-1:0]  rsp_rdata_d;

  apb_slave_decode #(
    .ADDR_W  (ADDR_W),
    .NUM_SLV (NUM_SLV),
    .SEL_W   (SEL_W)
  ) u_decode (
    .cmd_addr    (cmd_addr),
    .slv_idx     (dec_idx),
    .slv_onehot  (dec_onehot),
    .index_valid (dec_valid)
  );

  assign cmd_ready = (state_q == IDLE) && !PRESET;
  assign accept    = cmd_valid && cmd_ready;
  assign PSEL      = (state_q == IDLE) ? '0 : psel_q;
  assign PENABLE   = (state_q == ACCESS);
  assign dbg_state = state_q;

  // Pick the addressed slave's response; all other slaves are ignored.
  always_comb begin
    sel_ready = 1'b0;
    sel_err   = 1'b0;
    sel_rdata = '0;
    for (int s = 0; s < NUM_SLV; s++) begin
      if (idx_q == SEL_W'(s)) begin
        sel_ready = PREADY[s];
        sel_err   = PSLVERR[s];
        sel_rdata = PRDATA[s*DATA_W +: DATA_W];
      end
    end
  end

`ifdef APB_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TMO_W-1:0] tmo_cnt_q;

  // Count ACCESS cycles spent waiting for PREADY; restarts in every SETUP.
  always_ff @(posedge PCLK) begin
    if (PRESET || (state_q == SETUP)) tmo_cnt_q <= '0;
    else if ((state_q == ACCESS) && !sel_ready) tmo_cnt_q <= tmo_cnt_q + 1'b1;
  end

  // Fires in the TIMEOUT_CYC-th waiting ACCESS cycle.
  assign tmo_hit = (tmo_cnt_q == TMO_W'(TIMEOUT_CYC - 1));
`else
  assign tmo_hit = 1'b0;
`endif

  // State register.
  always_ff @(posedge PCLK) begin
    if (PRESET) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state and the response to publish in the following cycle.
  always_comb begin
    state_d     = state_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = '0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (dec_valid) begin
            state_d = SETUP;
          end else begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
          end
        end
      end
      SETUP: state_d = ACCESS;
      ACCESS: begin
        if (sel_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b1;
          rsp_err_d   = sel_err;
          rsp_rdata_d = (!PWRITE && !sel_err) ? sel_rdata : '0;
        end else if (tmo_hit) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Response registers: a one-cycle pulse, zero otherwise.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      rsp_valid <= rsp_valid_d;
      rsp_err   <= rsp_err_d;
      rsp_rdata <= rsp_rdata_d;
    end
  end

  // Latch a decodable command; APB fields then hold until the next one.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      PADDR  <= '0;
      PWRITE <= 1'b0;
      PWDATA <= '0;
      PSTRB  <= '0;
      idx_q  <= '0;
      psel_q <= '0;
    end else if (accept && dec_valid) begin
      PADDR  <= cmd_addr;
      PWRITE <= cmd_write;
      PWDATA <= cmd_wdata;
      PSTRB  <= cmd_write ? cmd_strb : {STRB_W{1'b0}};
      idx_q  <= dec_idx;
      psel_q <= dec_onehot;
    end
  end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Self-checking bench for apb_master_bridge: directed vector table, reset and
// wait/timeout sequences, then randomized transfers against a response model.
module tb_apb_master_bridge;

  localparam int ADDR_W  = 12;
  localparam int DATA_W  = 32;
  localparam int NUM_SLV = 3;
  localparam int STRB_W  = DATA_W / 8;
  localparam int SEL_W   = 2;

  logic                      PCLK = 1'b0;
  logic                      PRESET;
  logic                      cmd_valid, cmd_ready, cmd_write;
  logic [ADDR_W-1:0]         cmd_addr;
  logic [DATA_W-1:0]         cmd_wdata;
  logic [STRB_W-1:0]         cmd_strb;
  logic                      rsp_valid, rsp_err;
  logic [DATA_W-1:0]         rsp_rdata;
  logic [NUM_SLV-1:0]        PSEL;
  logic                      PENABLE, PWRITE;
  logic [ADDR_W-1:0]         PADDR;
  logic [DATA_W-1:0]         PWDATA;
  logic [STRB_W-1:0]         PSTRB;
  logic [NUM_SLV*DATA_W-1:0] PRDATA;
  logic [NUM_SLV-1:0]        PREADY, PSLVERR;
  logic [1:0]                dbg_state;

  apb_master_bridge #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_SLV(NUM_SLV), .TIMEOUT_CYC(16)
  ) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
    .PWDATA(PWDATA), .PSTRB(PSTRB), .PRDATA(PRDATA), .PREADY(PREADY),
    .PSLVERR(PSLVERR), .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 PCLK = ~PCLK;

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_bad = 0;
  logic [DATA_W:0] exp_q[$];   // {err, rdata} per accepted command

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: response from the address map and the slave's answer.
  function automatic logic [DATA_W:0] model_rsp(input logic wr, input logic [ADDR_W-1:0] addr,
                                               input logic slverr, input logic [DATA_W-1:0] prdata);
    int idx;
    idx = int'(addr) / (1 << (ADDR_W - SEL_W));
    if (idx >= NUM_SLV) return {1'b1, {DATA_W{1'b0}}};
    if (slverr)         return {1'b1, {DATA_W{1'b0}}};
    if (wr)             return {1'b0, {DATA_W{1'b0}}};
    return {1'b0, prdata};
  endfunction

  // ---------------- driver tasks ----------------
  // Slave idx answers as given; every other slave drives random noise.
  task automatic set_slaves(input int idx, input logic rdy, input logic err, input logic [DATA_W-1:0] rd);
    for (int s = 0; s < NUM_SLV; s++) begin
      if (s == idx) begin
        PREADY[s] = rdy;
        PSLVERR[s] = err;
        PRDATA[s*DATA_W +: DATA_W] = rd;
      end else begin
        PREADY[s] = 1'($urandom_range(0, 1));
        PSLVERR[s] = 1'($urandom_range(0, 1));
        PRDATA[s*DATA_W +: DATA_W] = $urandom;
      end
    end
  endtask

  // Full transfer, entered and left at a negedge with the bridge idle.
  task automatic run_xfer(input string tag, input logic wr, input logic [ADDR_W-1:0] addr,
                          input logic [DATA_W-1:0] wdata, input logic [STRB_W-1:0] strb,
                          input int waits, input logic slverr, input logic [DATA_W-1:0] prdata,
                          input logic [DATA_W:0] exp_rsp);
    int idx;
    logic [NUM_SLV-1:0] exp_sel;
    logic [STRB_W-1:0] exp_strb;
    logic [DATA_W:0] e;
    idx = int'(addr) / (1 << (ADDR_W - SEL_W));
    exp_strb = wr ? strb : '0;
    check({tag, " ready_idle"}, cmd_ready, 1);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wdata; cmd_strb = strb;
    set_slaves(-1, 1'b0, 1'b0, '0);
    exp_q.push_back(exp_rsp);
    @(negedge PCLK);
    cmd_valid = 1'b0; cmd_write = 1'($urandom_range(0, 1)); cmd_addr = ADDR_W'($urandom);
    cmd_wdata = $urandom; cmd_strb = STRB_W'($urandom);
    if (idx >= NUM_SLV) begin
      e = exp_q.pop_front();
      check({tag, " decerr_rsp_valid"}, rsp_valid, 1);
      check({tag, " decerr_rsp_err"}, rsp_err, e[DATA_W]);
      check({tag, " decerr_rdata"}, rsp_rdata, e[DATA_W-1:0]);
      check({tag, " decerr_psel"}, PSEL, 0);
      check({tag, " decerr_ready"}, cmd_ready, 1);
      return;
    end
    exp_sel = NUM_SLV'(1) << idx;
    check({tag, " setup_psel"}, PSEL, exp_sel);
    check({tag, " setup_penable"}, PENABLE, 0);
    check({tag, " setup_paddr"}, PADDR, addr);
    check({tag, " setup_pwrite"}, PWRITE, wr);
    check({tag, " setup_pwdata"}, PWDATA, wdata);
    check({tag, " setup_pstrb"}, PSTRB, exp_strb);
    check({tag, " setup_ready"}, cmd_ready, 0);
    check({tag, " quiet_rsp"}, {rsp_valid, rsp_err, rsp_rdata}, 0);
    set_slaves(idx, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
    for (int k = 0; k <= waits; k++) begin
      @(negedge PCLK);
      check({tag, " acc_psel"}, PSEL, exp_sel);
      check({tag, " acc_penable"}, PENABLE, 1);
      check({tag, " acc_hold"}, {PADDR, PWRITE, PWDATA, PSTRB}, {addr, wr, wdata, exp_strb});
      check({tag, " acc_rsp_valid"}, rsp_valid, 0);
      set_slaves(idx, (k == waits), (k == waits) ? slverr : 1'b1, (k == waits) ? prdata : $urandom);
    end
    @(negedge PCLK);
    e = exp_q.pop_front();
    check({tag, " rsp_valid"}, rsp_valid, 1);
    check({tag, " rsp_err"}, rsp_err, e[DATA_W]);
    check({tag, " rsp_rdata"}, rsp_rdata, e[DATA_W-1:0]);
    check({tag, " end_bus"}, {PSEL, PENABLE}, 0);
    check({tag, " end_ready"}, cmd_ready, 1);
    check({tag, " end_paddr_held"}, PADDR, addr);
    set_slaves(-1, 1'b0, 1'b0, '0);
  endtask

  typedef struct {
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] strb;
    int                waits;
    logic              slverr;
    logic [DATA_W-1:0] prdata;
    logic              exp_err;
    logic [DATA_W-1:0] exp_rdata;
  } vec_t;

  vec_t vecs[8];

  // ---------------- stimulus ----------------
  initial begin
    logic wr, se;
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] wd, pd;
    logic [STRB_W-1:0] sb;
    int w;

    vecs[0] = '{1'b1, 12'h504, 32'hDEADBEEF, 4'hF, 0, 1'b0, 32'h11111111, 1'b0, 32'h0};
    vecs[1] = '{1'b0, 12'h808, 32'h00000000, 4'hF, 3, 1'b0, 32'h12345678, 1'b0, 32'h12345678};
    vecs[2] = '{1'b0, 12'h010, 32'h00000000, 4'h0, 0, 1'b1, 32'hCAFEF00D, 1'b1, 32'h0};
    vecs[3] = '{1'b0, 12'h014, 32'h00000000, 4'h0, 2, 1'b0, 32'h0BADC0DE, 1'b0, 32'h0BADC0DE};
    vecs[4] = '{1'b1, 12'hC00, 32'h55AA55AA, 4'hF, 0, 1'b0, 32'h0, 1'b1, 32'h0};
    vecs[5] = '{1'b0, 12'hFFC, 32'h00000000, 4'h0, 0, 1'b0, 32'h77777777, 1'b1, 32'h0};
    vecs[6] = '{1'b1, 12'h9F0, 32'h01020304, 4'h3, 1, 1'b1, 32'hFFFFFFFF, 1'b1, 32'h0};
    vecs[7] = '{1'b0, 12'h7FC, 32'h00000000, 4'h0, 0, 1'b0, 32'h89ABCDEF, 1'b0, 32'h89ABCDEF};

    // reset
    PRESET = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_strb = '0;
    PREADY = '0; PSLVERR = '0; PRDATA = '0;
    repeat (3) @(negedge PCLK);
    check("reset_outputs", {cmd_ready, rsp_valid, rsp_err, rsp_rdata, PSEL, PENABLE, PWRITE}, 0);
    check("reset_apb_fields", {PADDR, PWDATA, PSTRB}, 0);
    check("reset_state", dbg_state, 0);
    PRESET = 1'b0;
    #1 check("reset_release_ready", cmd_ready, 1);
    @(negedge PCLK);

    // directed vector table
    for (int i = 0; i < 8; i++) begin
      run_xfer($sformatf("vec%0d", i), vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].strb,
               vecs[i].waits, vecs[i].slverr, vecs[i].prdata, {vecs[i].exp_err, vecs[i].exp_rdata});
    end

    // reset pulsed during ACCESS drops the transfer without a response
    check("rst_ready", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 12'h504; cmd_wdata = 32'h0F0F0F0F; cmd_strb = 4'hF;
    set_slaves(1, 1'b0, 1'b0, '0);
    @(negedge PCLK);
    cmd_valid = 1'b0;
    check("rst_setup_psel", PSEL, 3'b010);
    @(negedge PCLK);
    check("rst_access_penable", PENABLE, 1);
    PRESET = 1'b1;
    @(negedge PCLK);
    check("rst_bus_idle", {PSEL, PENABLE}, 0);
    check("rst_no_rsp", {rsp_valid, rsp_err, rsp_rdata}, 0);
    check("rst_ready_low", cmd_ready, 0);
    check("rst_paddr_cleared", PADDR, 0);
    PRESET = 1'b0;
    set_slaves(-1, 1'b0, 1'b0, '0);
    #1 check("rst_ready_after", cmd_ready, 1);
    @(negedge PCLK);
    check("rst_still_no_rsp", rsp_valid, 0);
    check("rst_psel_after", PSEL, 0);

    // PREADY held low on slave 0
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 12'h020; cmd_strb = 4'h0;
    set_slaves(0, 1'b0, 1'b0, '0);
    @(negedge PCLK);
    cmd_valid = 1'b0;
    check("tmo_setup_psel", PSEL, 3'b001);
`ifdef APB_TIMEOUT_EN
    for (int k = 0; k < 16; k++) begin
      @(negedge PCLK);
      check("tmo_wait_access", {PSEL, PENABLE, rsp_valid}, {3'b001, 1'b1, 1'b0});
      set_slaves(0, 1'b0, 1'b1, $urandom);
    end
    @(negedge PCLK);
    check("tmo_abort_rsp", {rsp_valid, rsp_err, rsp_rdata}, {1'b1, 1'b1, 32'h0});
    check("tmo_abort_bus", {PSEL, PENABLE}, 0);
    check("tmo_abort_ready", cmd_ready, 1);
    set_slaves(-1, 1'b0, 1'b0, '0);
`else
    for (int k = 0; k < 100; k++) begin
      @(negedge PCLK);
      check("wait_access", {PSEL, PENABLE, rsp_valid}, {3'b001, 1'b1, 1'b0});
      set_slaves(0, 1'b0, 1'b1, $urandom);
    end
    check("wait_state", dbg_state, 2);
    set_slaves(0, 1'b1, 1'b0, 32'hA5A5A5A5);
    @(negedge PCLK);
    check("wait_release_rsp", {rsp_valid, rsp_err, rsp_rdata}, {1'b1, 1'b0, 32'hA5A5A5A5});
    check("wait_release_bus", {PSEL, PENABLE}, 0);
    set_slaves(-1, 1'b0, 1'b0, '0);
`endif
    @(negedge PCLK);
    check("post_wait_quiet", {rsp_valid, rsp_err, rsp_rdata}, 0);

    // randomized transfers against the response model
    for (int i = 0; i < 40; i++) begin
      wr = 1'($urandom_range(0, 1));
      a  = ADDR_W'($urandom_range(0, (1 << ADDR_W) - 1));
      wd = $urandom;
      sb = STRB_W'($urandom);
      w  = $urandom_range(0, 4);
      se = ($urandom_range(0, 3) == 0);
      pd = $urandom;
      run_xfer($sformatf("rnd%0d", i), wr, a, wd, sb, w, se, pd, model_rsp(wr, a, se, pd));
      if ($urandom_range(0, 3) == 0) begin
        @(negedge PCLK);
        check("rnd_gap_quiet", {rsp_valid, rsp_err, rsp_rdata}, 0);
      end
    end
    check("scoreboard_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Hard bound on run time.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
